// File: rtl/puf_resp_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : puf_resp_collector
// Purpose  : Triggers a single-bit CT-PUF core repeatedly, majority-votes each
//            response bit over VOTES evaluations, assembles a RESP_BITS word,
//            counts non-unanimous bits and hands the word off via valid/ack.
// Revision : 1.0 - initial release
// ============================================================================
module puf_resp_collector #(
    parameter int RESP_BITS   = 8,   // response bits per word
    parameter int VOTES       = 5,   // evaluations per bit, odd and >= 1
    parameter int TRIG_CYCLES = 2,   // trig high cycles per evaluation, >= 1
    parameter int SETTLE      = 4    // trig low cycles before sampling, >= 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             ack,
    input  logic                             puf_bit,
    output logic                             trig,
    output logic                             busy,
    output logic                             valid,
    output logic [RESP_BITS-1:0]             resp,
    output logic [$clog2(RESP_BITS+1)-1:0]   unstable_cnt
);

    localparam int c_ONES_W = $clog2(VOTES + 1);
    localparam int c_UNST_W = $clog2(RESP_BITS + 1);
    localparam int c_BIT_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int c_VOTE_W = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int c_CNT_MAX = (TRIG_CYCLES > SETTLE) ? TRIG_CYCLES : SETTLE;
    localparam int c_CNT_W  = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0]  c_TRIG_LAST   = c_CNT_W'(TRIG_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_SETTLE_LAST = c_CNT_W'(SETTLE - 1);
    localparam logic [c_VOTE_W-1:0] c_VOTE_LAST   = c_VOTE_W'(VOTES - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST    = c_BIT_W'(RESP_BITS - 1);
    localparam logic [c_ONES_W-1:0] c_ONES_ALL    = c_ONES_W'(VOTES);
    localparam logic [c_ONES_W-1:0] c_ONES_HALF   = c_ONES_W'(VOTES / 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TRIG   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DECIDE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_VOTE_W-1:0]  r_vote_idx;
    logic [c_BIT_W-1:0]   r_bit_idx;
    logic [c_ONES_W-1:0]  r_ones;
    logic [RESP_BITS-1:0] r_resp;
    logic [c_UNST_W-1:0]  r_unst;
    logic                 w_trig;
    logic                 w_busy;
    logic                 w_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs depend on the registered state only, so trig cannot glitch.
    always_comb begin
        w_next_state = r_state;
        w_trig       = 1'b0;
        w_busy       = 1'b1;
        w_valid      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) w_next_state = S_TRIG;
            end
            S_TRIG: begin
                w_trig = 1'b1;
                if (r_cnt == c_TRIG_LAST) w_next_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) w_next_state = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_next_state = (r_vote_idx == c_VOTE_LAST) ? S_DECIDE : S_TRIG;
            end
            S_DECIDE: begin
                w_next_state = (r_bit_idx == c_BIT_LAST) ? S_DONE : S_TRIG;
            end
            S_DONE: begin
                w_busy  = 1'b0;
                w_valid = 1'b1;
                if (ack) w_next_state = S_IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_cnt      <= '0;
            r_vote_idx <= '0;
            r_bit_idx  <= '0;
            r_ones     <= '0;
            r_resp     <= '0;
            r_unst     <= '0;
        end else begin
            r_sync1 <= puf_bit;
            r_sync2 <= r_sync1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_resp     <= '0;
                        r_unst     <= '0;
                        r_bit_idx  <= '0;
                        r_vote_idx <= '0;
                        r_ones     <= '0;
                        r_cnt      <= '0;
                    end
                end
                S_TRIG: begin
                    r_cnt <= (r_cnt == c_TRIG_LAST) ? '0 : r_cnt + c_CNT_W'(1);
                end
                S_SETTLE: begin
                    r_cnt <= (r_cnt == c_SETTLE_LAST) ? '0 : r_cnt + c_CNT_W'(1);
                end
                S_SAMPLE: begin
                    r_ones <= r_ones + c_ONES_W'(r_sync2);
                    if (r_vote_idx != c_VOTE_LAST) begin
                        r_vote_idx <= r_vote_idx + c_VOTE_W'(1);
                    end
                end
                S_DECIDE: begin
                    r_resp[r_bit_idx] <= (r_ones > c_ONES_HALF);
                    // A bit is unstable when its votes were split.
                    if ((r_ones != '0) && (r_ones != c_ONES_ALL)) begin
                        r_unst <= r_unst + c_UNST_W'(1);
                    end
                    r_ones     <= '0;
                    r_vote_idx <= '0;
                    if (r_bit_idx != c_BIT_LAST) begin
                        r_bit_idx <= r_bit_idx + c_BIT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign trig         = w_trig;
    assign busy         = w_busy;
    assign valid        = w_valid;
    assign resp         = r_resp;
    assign unstable_cnt = r_unst;

endmodule
`default_nettype wire

// File: tb/tb_puf_resp_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_puf_resp_collector
// Purpose  : Scoreboard bench for puf_resp_collector; drives per-evaluation
//            PUF vote patterns keyed on trig pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_puf_resp_collector;

    localparam int RESP_BITS   = 8;
    localparam int VOTES       = 5;
    localparam int TRIG_CYCLES = 2;
    localparam int SETTLE      = 4;
    localparam int NPULSE      = RESP_BITS * VOTES;
    localparam int LATENCY     = RESP_BITS * (VOTES * (TRIG_CYCLES + SETTLE + 1) + 1);
    localparam int BUDGET      = 400;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       start   = 1'b0;
    logic       ack     = 1'b0;
    logic       puf_bit = 1'b0;
    logic       trig;
    logic       busy;
    logic       valid;
    logic [7:0] resp;
    logic [3:0] unstable_cnt;

    int checks   = 0;
    int failures = 0;

    logic [NPULSE-1:0] vote_tbl  = '0;
    int                pulse_cnt = 0;
    logic              trig_q    = 1'b0;
    logic [11:0]       sb_q[$];

    puf_resp_collector #(
        .RESP_BITS   (RESP_BITS),
        .VOTES       (VOTES),
        .TRIG_CYCLES (TRIG_CYCLES),
        .SETTLE      (SETTLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ack          (ack),
        .puf_bit      (puf_bit),
        .trig         (trig),
        .busy         (busy),
        .valid        (valid),
        .resp         (resp),
        .unstable_cnt (unstable_cnt)
    );

    always #5 clk = ~clk;

    // Each trig rising edge starts evaluation pulse_cnt: present its vote.
    always @(negedge clk) begin
        if (trig && !trig_q) begin
            if (pulse_cnt < NPULSE) puf_bit = vote_tbl[pulse_cnt];
            pulse_cnt++;
        end
        trig_q = trig;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pattern(input logic [7:0] pat);
        for (int k = 0; k < NPULSE; k++) vote_tbl[k] = pat[k / VOTES];
    endtask

    task automatic start_run(input bit push, input logic [7:0] er, input logic [3:0] eu);
        pulse_cnt = 0;
        if (push) sb_q.push_back({er, eu});
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (valid !== 1'b1 && n < BUDGET) begin
            tick();
            n++;
        end
    endtask

    task automatic pop_exp(output logic [7:0] er, output logic [3:0] eu);
        if (sb_q.size() == 0) begin
            er = 'x;
            eu = 'x;
        end else begin
            {er, eu} = sb_q.pop_front();
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({trig, busy, valid, resp, unstable_cnt} !== 15'd0) begin
            failures++;
            $display("FAIL reset_state: got %0h expected 0", {trig, busy, valid, resp, unstable_cnt});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_constant_ones();
        int n;
        logic [7:0] er;
        logic [3:0] eu;
        load_pattern(8'hFF);
        start_run(1'b1, 8'hFF, 4'd0);
        wait_valid(n);
        pop_exp(er, eu);
        checks++;
        if (n != LATENCY) begin
            failures++;
            $display("FAIL ones_latency: got %0d expected %0d", n, LATENCY);
        end
        checks++;
        if (resp !== er || unstable_cnt !== eu) begin
            failures++;
            $display("FAIL ones_result: got %0h/%0d expected %0h/%0d", resp, unstable_cnt, er, eu);
        end
        checks++;
        if (pulse_cnt != NPULSE) begin
            failures++;
            $display("FAIL ones_trig_pulses: got %0d expected %0d", pulse_cnt, NPULSE);
        end
        do_ack();
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ones_ack: got valid=%b busy=%b expected 0/0", valid, busy);
        end
    endtask

    task automatic test_stable_pattern();
        int n;
        logic [7:0] er;
        logic [3:0] eu;
        load_pattern(8'hA5);
        start_run(1'b1, 8'hA5, 4'd0);
        wait_valid(n);
        pop_exp(er, eu);
        checks++;
        if (n != LATENCY || resp !== er || unstable_cnt !== eu) begin
            failures++;
            $display("FAIL stable_a5: got lat=%0d %0h/%0d expected lat=%0d %0h/%0d",
                     n, resp, unstable_cnt, LATENCY, er, eu);
        end
        do_ack();
    endtask

    task automatic test_noisy_bits();
        int n;
        logic [7:0] er;
        logic [3:0] eu;
        logic [4:0] v2 = 5'b01101;   // votes 1,0,1,1,0 in order 0..4
        logic [4:0] v5 = 5'b10010;   // votes 0,1,0,0,1 in order 0..4
        load_pattern(8'h00);
        for (int v = 0; v < VOTES; v++) begin
            vote_tbl[2 * VOTES + v] = v2[v];
            vote_tbl[5 * VOTES + v] = v5[v];
        end
        start_run(1'b1, 8'h04, 4'd2);
        wait_valid(n);
        pop_exp(er, eu);
        checks++;
        if (n != LATENCY) begin
            failures++;
            $display("FAIL noisy_latency: got %0d expected %0d", n, LATENCY);
        end
        checks++;
        if (resp !== er) begin
            failures++;
            $display("FAIL noisy_resp: got %0h expected %0h", resp, er);
        end
        checks++;
        if (unstable_cnt !== eu) begin
            failures++;
            $display("FAIL noisy_unstable: got %0d expected %0d", unstable_cnt, eu);
        end
        do_ack();
    endtask

    task automatic test_handshake();
        int n;
        int pulses_at_done;
        int bad_hold = 0;
        logic [7:0] er;
        logic [3:0] eu;
        load_pattern(8'h3C);
        start_run(1'b1, 8'h3C, 4'd0);
        wait_valid(n);
        pop_exp(er, eu);
        checks++;
        if (resp !== er || unstable_cnt !== eu) begin
            failures++;
            $display("FAIL hs_result: got %0h/%0d expected %0h/%0d", resp, unstable_cnt, er, eu);
        end
        pulses_at_done = pulse_cnt;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid !== 1'b1 || resp !== er || trig !== 1'b0) bad_hold++;
        end
        checks++;
        if (bad_hold != 0 || pulse_cnt != pulses_at_done) begin
            failures++;
            $display("FAIL hs_hold: got %0d bad cycles, %0d pulses expected 0, %0d",
                     bad_hold, pulse_cnt, pulses_at_done);
        end
        // start and ack together in DONE: ack wins.
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL hs_ack_wins: got valid=%b busy=%b expected 0/0", valid, busy);
        end
        // start still high in the following IDLE cycle: new run, resp cleared.
        load_pattern(8'hFF);
        pulse_cnt = 0;
        sb_q.push_back({8'hFF, 4'd0});
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || resp !== 8'h00 || unstable_cnt !== 4'd0) begin
            failures++;
            $display("FAIL b2b_restart: got busy=%b resp=%0h unst=%0d expected 1/0/0",
                     busy, resp, unstable_cnt);
        end
        wait_valid(n);
        pop_exp(er, eu);
        checks++;
        if (n != LATENCY || resp !== er || unstable_cnt !== eu) begin
            failures++;
            $display("FAIL b2b_result: got lat=%0d %0h/%0d expected lat=%0d %0h/%0d",
                     n, resp, unstable_cnt, LATENCY, er, eu);
        end
        do_ack();
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] er;
        logic [3:0] eu;
        logic [4:0] vn = 5'b11011;
        load_pattern(8'h00);
        for (int v = 0; v < VOTES; v++) begin
            vote_tbl[v]         = vn[v];
            vote_tbl[VOTES + v] = vn[v];
        end
        start_run(1'b0, 8'h00, 4'd0);
        for (int i = 1; i < 100; i++) tick();
        checks++;
        if (resp !== 8'h03 || unstable_cnt !== 4'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre_reset: got %0h/%0d busy=%b expected 03/2/1", resp, unstable_cnt, busy);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({trig, busy, valid, resp, unstable_cnt} !== 15'd0) begin
            failures++;
            $display("FAIL mid_async_reset: got %0h expected 0", {trig, busy, valid, resp, unstable_cnt});
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        load_pattern(8'h00);
        start_run(1'b1, 8'h00, 4'd0);
        wait_valid(n);
        pop_exp(er, eu);
        checks++;
        if (n != LATENCY || resp !== er || unstable_cnt !== eu) begin
            failures++;
            $display("FAIL mid_rerun: got lat=%0d %0h/%0d expected lat=%0d %0h/%0d",
                     n, resp, unstable_cnt, LATENCY, er, eu);
        end
        do_ack();
    endtask

    task automatic test_start_ignored();
        int n = 0;
        int busy_after = 0;
        logic [7:0] er;
        logic [3:0] eu;
        load_pattern(8'h96);
        start_run(1'b1, 8'h96, 4'd0);
        while (valid !== 1'b1 && n < BUDGET) begin
            tick();
            n++;
            start = (n == 50 || n == 150);
            ack   = (n >= 60 && n <= 70);
        end
        start = 1'b0;
        ack   = 1'b0;
        pop_exp(er, eu);
        checks++;
        if (n != LATENCY) begin
            failures++;
            $display("FAIL ignore_latency: got %0d expected %0d", n, LATENCY);
        end
        checks++;
        if (resp !== er || unstable_cnt !== eu || pulse_cnt != NPULSE) begin
            failures++;
            $display("FAIL ignore_result: got %0h/%0d pulses=%0d expected %0h/%0d pulses=%0d",
                     resp, unstable_cnt, pulse_cnt, er, eu, NPULSE);
        end
        do_ack();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy !== 1'b0 || valid !== 1'b0) busy_after++;
        end
        checks++;
        if (busy_after != 0) begin
            failures++;
            $display("FAIL ignore_single_run: got %0d active cycles expected 0", busy_after);
        end
    endtask

    initial begin
        test_reset();
        test_constant_ones();
        test_stable_pattern();
        test_noisy_bits();
        test_handshake();
        test_reset_mid();
        test_start_ignored();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/puf_resp_collector.md
Name: puf_resp_collector

Overview:
- Downstream consumer of the single-bit CT-PUF core. Drives the core's trigger input T and samples its final output bit.
- For each response bit, repeats the evaluation VOTES times and applies temporal majority voting to suppress noise.
- Assembles a RESP_BITS-wide response word, counts unstable (non-unanimous) bits, and presents the result with a valid/ack handshake to the Tiny Tapeout wrapper logic.

Parameters:
- RESP_BITS, 8, number of response bits per word.
- VOTES, 5, evaluations per bit. Must be odd and ≥1.
- TRIG_CYCLES, 2, cycles trig is held high per evaluation. Must be ≥1.
- SETTLE, 4, cycles trig is held low before sampling. Must be ≥2, which covers the synchronizer.

Ports:
- clk, input, 1, single system clock.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, request a new response word. Sampled only in IDLE.
- ack, input, 1, consumer accepts the response. Sampled only in DONE.
- puf_bit, input, 1, CT-PUF final output (fnlout). Treated as asynchronous.
- trig, output, 1, drives the PUF core T input.
- busy, output, 1, high in every state except IDLE and DONE.
- valid, output, 1, high in DONE only.
- resp, output, RESP_BITS, majority-voted response. Bit i is the i-th evaluated bit.
- unstable_cnt, output, clog2(RESP_BITS+1), number of bits whose votes were not unanimous.

Behaviour:
- Reset (reset=0, async): state=IDLE; trig, busy, valid=0; resp=0; unstable_cnt=0; all counters and synchronizer flops=0. Outputs go low immediately, including mid-operation.
- Synchronizer: puf_bit passes through a 2-flop synchronizer, always enabled. The SAMPLE state captures the second flop.
- State machine (registered state; outputs decoded from state):
  - IDLE: if start=1, then resp<=0, unstable_cnt<=0, bit_idx<=0, vote_idx<=0, ones<=0, next state TRIG. Otherwise stay.
  - TRIG: trig=1 for TRIG_CYCLES cycles, then SETTLE.
  - SETTLE: trig=0 for SETTLE cycles, then SAMPLE.
  - SAMPLE: 1 cycle; ones<=ones+sync_bit.
    - If vote_idx==VOTES-1, go to DECIDE.
    - Else vote_idx++ and go to TRIG.
  - DECIDE: 1 cycle.
    - resp[bit_idx] <= (ones > VOTES/2).
    - If ones is neither 0 nor VOTES, unstable_cnt++.
    - Clear ones and vote_idx.
    - If bit_idx==RESP_BITS-1, go to DONE. Else bit_idx++ and go to TRIG.
  - DONE: valid=1; resp and unstable_cnt held stable. If ack=1, go to IDLE; valid drops on that edge.
- Widths: ones is clog2(VOTES+1) bits and never wraps. bit_idx and vote_idx never exceed their terminal values.
- Latency: valid rises exactly RESP_BITS*(VOTES*(TRIG_CYCLES+SETTLE+1)+1) clock edges after the edge that samples start. With defaults this is 288.
- Boundary conditions:
  - start while busy or in DONE: ignored.
  - ack outside DONE: ignored.
  - start and ack both high in DONE: ack is honoured; start is ignored that cycle.
  - start high in the IDLE cycle following DONE: a new run begins, and resp is cleared at that edge.
  - VOTES=1: DECIDE copies the sample; unstable_cnt stays 0.
- trig is glitch-free: it is decoded only from the registered state and never combinationally from inputs.

Test Plan:
- Constant ones: puf_bit=1, pulse start 1 cycle → trig toggles 40 times (5 votes × 8 bits, each high 2 cycles); valid rises 288 edges after start; resp=8'hFF; unstable_cnt=0.
- Stable pattern: bench sets puf_bit during each TRIG phase to bit i of 8'hA5 → resp=8'hA5; unstable_cnt=0.
- Noisy bits:
  - Bit 2 votes 1,0,1,1,0 → resp[2]=1.
  - Bit 5 votes 0,1,0,0,1 → resp[5]=0.
  - Other bits unanimous 0 → resp=8'h04; unstable_cnt=2.
- Handshake: hold ack=0 for 10 cycles in DONE while pulsing start → valid stays 1, resp stays constant, no trig activity. Then ack=1 for 1 cycle → valid=0 next edge, busy=0.
- Reset mid-operation: assert reset=0 at cycle 100 → trig, busy, valid, resp and unstable_cnt go to 0 without waiting for a clock edge. Release reset, then start with puf_bit=0 → resp=8'h00 at 288 edges.
- Start ignored while busy: pulse start at cycles 50 and 150 of a run → exactly one run completes; valid rises at edge 288 from the first start.
